// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // Samples sit at P/2-SMP_OFS, P/2 and P/2+SMP_OFS; the vote is taken at the last one.
  localparam int unsigned SMP_OFS = 1;

  localparam logic [3:0] LEN_MIN = 4'd5;
  localparam logic [3:0] LEN_MAX = 4'd9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer plus 3-sample majority vote around the bit centre.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic                      rx_sync,
  output logic                      bit_val,
  output logic                      bit_strobe
);

  logic                      sync_p0;
  logic                      sync_p1;
  logic                      smp_a;
  logic                      smp_b;
  logic [PRESCALE_WIDTH-1:0] half;
  logic [PRESCALE_WIDTH-1:0] pt_a;
  logic [PRESCALE_WIDTH-1:0] pt_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rx_in;
      sync_p1 <= sync_p0;
    end
  end

  assign rx_sync = sync_p1;
  assign half    = prescale >> 1;
  assign pt_a    = half - PRESCALE_WIDTH'(SMP_OFS);
  assign pt_c    = half + PRESCALE_WIDTH'(SMP_OFS);

  always_ff @(posedge clk) begin
    if (edge_cnt == pt_a) smp_a <= rx_sync;
    if (edge_cnt == half) smp_b <= rx_sync;
  end

  // The third sample is the live synchronized line, so the vote resolves on the strobe cycle.
  assign bit_strobe = (edge_cnt == pt_c);
  assign bit_val    = maj3(smp_a, smp_b, rx_sync);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: framing FSM, shift register and valid/ready output register.
module uart_rx_cfg
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [3:0]                DATA_LEN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP2,
  input  logic                      data_ready,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      frm_err,
  output logic                      brk_det,
  output logic                      overrun
);

  localparam logic [3:0] LEN_TOP = (DATA_WIDTH > int'(LEN_MAX)) ? LEN_MAX : 4'(DATA_WIDTH);

  rx_state_e                 state;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [3:0]                bit_cnt;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [3:0]                len_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic                      stop2_q;
  logic [DATA_WIDTH-1:0]     shreg;
  logic                      par_acc;
  logic                      par_bad;
  logic                      par_bit;
  logic                      stop1_val;
  logic                      frm_acc;

  logic       rx_sync;
  logic       bit_val;
  logic       bit_strobe;
  logic       wrap;
  logic       start_det;
  logic [3:0] cfg_len;
  logic       done;
  logic       done_frm;
  logic       done_stop1;
  logic       done_brk;
  logic       done_par;
  logic       load;

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .clk       (CLK),
    .rst_n     (RST),
    .rx_in     (RX_IN),
    .prescale  (prescale_q),
    .edge_cnt  (edge_cnt),
    .rx_sync   (rx_sync),
    .bit_val   (bit_val),
    .bit_strobe(bit_strobe)
  );

  assign cfg_len   = (DATA_LEN < LEN_MIN || DATA_LEN > LEN_TOP) ? LEN_TOP : DATA_LEN;
  assign wrap      = (edge_cnt == prescale_q - PRESCALE_WIDTH'(1));
  assign start_det = (state == IDLE) && !rx_sync;

  // Frame completes on the vote of the last stop bit; flags are assembled from the live vote.
  assign done       = (state == STOP) && bit_strobe && (bit_cnt == {3'b000, stop2_q});
  assign done_frm   = frm_acc | ~bit_val;
  assign done_stop1 = (bit_cnt == 4'd0) ? bit_val : stop1_val;
  assign done_brk   = (shreg == '0) & ~(par_en_q & par_bit) & ~done_stop1;
  assign done_par   = par_en_q & par_bad;
  assign load       = done & (~data_valid | data_ready);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      edge_cnt <= wrap ? '0 : edge_cnt + PRESCALE_WIDTH'(1);
      case (state)
        IDLE: begin
          edge_cnt <= '0;
          if (!rx_sync) begin
            state    <= START;
            edge_cnt <= PRESCALE_WIDTH'(1);
          end
        end
        START: begin
          if (bit_strobe && bit_val) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (wrap) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (wrap) begin
            if (bit_cnt == len_q - 4'd1) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PARITY: begin
          if (wrap) begin
            state   <= STOP;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          if (done) begin
            state    <= done_frm ? WAIT_HIGH : IDLE;
            edge_cnt <= '0;
          end else if (wrap) begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end
        WAIT_HIGH: begin
          edge_cnt <= '0;
          if (rx_sync) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (start_det) begin
      prescale_q <= Prescale;
      len_q      <= cfg_len;
      par_en_q   <= PAR_EN;
      par_typ_q  <= PAR_TYP;
      stop2_q    <= STOP2;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      par_bit    <= 1'b0;
      stop1_val  <= 1'b1;
      frm_acc    <= 1'b0;
    end else if (bit_strobe) begin
      case (state)
        DATA: begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt == 4'(i)) shreg[i] <= bit_val;
          end
          par_acc <= par_acc ^ bit_val;
        end
        PARITY: begin
          par_bit <= bit_val;
          par_bad <= ((par_acc ^ bit_val) != par_typ_q);
        end
        STOP: begin
          if (!bit_val) frm_acc <= 1'b1;
          if (bit_cnt == 4'd0) stop1_val <= bit_val;
        end
        default: ;
      endcase
    end
  end

  // Output register: a held frame is never overwritten unless it is being consumed this cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      brk_det    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= done & ~load;
      if (load) begin
        P_DATA     <= shreg;
        par_err    <= done_par;
        frm_err    <= done_frm;
        brk_det    <= done_brk;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: directed frames, monitor pops expectations on each frame load.
module tb_uart_rx_cfg;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = 6'd8;
  logic [3:0]    DATA_LEN = 4'd8;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP2 = 1'b0;
  logic          data_ready = 1'b1;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          frm_err;
  logic          brk_det;
  logic          overrun;

  uart_rx_cfg #(
    .DATA_WIDTH(DW),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .DATA_LEN  (DATA_LEN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .STOP2     (STOP2),
    .data_ready(data_ready),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .frm_err   (frm_err),
    .brk_det   (brk_det),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    logic          frm;
    logic          brk;
    int            t;
  } exp_t;

  exp_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   ovr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic p, input logic f, input logic b, input int t);
    exp_t e;
    e.data = d; e.par = p; e.frm = f; e.brk = b; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int p, input int gpos);
    for (int j = 0; j < p; j++) begin
      RX_IN = (j == gpos) ? ~b : b;
      tick(1);
    end
  endtask

  // Start bit, LSB-first data, optional parity, stop bits (first one may be forced low).
  task automatic send_frame(input logic [8:0] d, input int len, input int p, input bit pen,
                            input logic pbit, input int nstop, input logic s1,
                            input int gbit, input int gpos);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < len; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(s1);
    for (int i = 1; i < nstop; i++) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++) send_bit(bits[k], p, (k == gbit) ? gpos : -1);
    RX_IN = 1'b1;
  endtask

  task automatic cfg(input int p, input int len, input bit pen, input bit ptyp, input bit s2);
    Prescale = PW'(p);
    DATA_LEN = 4'(len);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    STOP2    = s2;
  endtask

  // Monitor: a load is valid rising, or valid staying high right after a transfer.
  initial begin
    logic prev_valid;
    logic prev_hs;
    exp_t e;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
      end else begin
        if (overrun) ovr_cnt++;
        if (data_valid && (!prev_valid || prev_hs)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame actual=%0h required=none", P_DATA);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data_flags", 32'({P_DATA, par_err, frm_err, brk_det}),
                32'({e.data, e.par, e.frm, e.brk}));
            if (e.t >= 0) begin
              checks++;
              if (cyc < e.t - 1 || cyc > e.t + 1) begin
                errors++;
                $display("FAIL frame_time actual=%0d required=%0d", cyc, e.t);
              end
            end
          end
        end
        prev_valid = data_valid;
        prev_hs    = data_valid & data_ready;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr0;
    tick(3);
    chk("reset_outputs", 32'({P_DATA, data_valid, par_err, frm_err, brk_det, overrun}), 32'd0);
    chk("reset_state", 32'(dut.state), 32'(IDLE));
    RST = 1'b1;
    tick(4);

    // 8N1 0xA5, P=8: load expected (1+8)*8 + 4 + 2, plus 2 synchronizer cycles after the line edge.
    cfg(8, 8, 0, 0, 0);
    push(8'hA5, 0, 0, 0, cyc + 80);
    send_frame(9'h0A5, 8, 8, 0, 0, 1, 1, -1, 0);
    tick(16);

    // One-cycle glitches on a sample point inside a data bit.
    push(8'h3C, 0, 0, 0, -1);
    send_frame(9'h03C, 8, 8, 0, 0, 1, 1, 3, 4);
    tick(16);
    push(8'h3C, 0, 0, 0, -1);
    send_frame(9'h03C, 8, 8, 0, 0, 1, 1, 1, 5);
    tick(16);

    // Out-of-range length falls back to DATA_WIDTH.
    cfg(8, 3, 0, 0, 0);
    push(8'hA5, 0, 0, 0, -1);
    send_frame(9'h0A5, 8, 8, 0, 0, 1, 1, -1, 0);
    tick(16);

    // 7O2 at P=6: n = 1+7+1+1 = 10 -> 60 + 3 + 4 cycles.
    cfg(6, 7, 1, 1, 1);
    push(8'h41, 0, 0, 0, cyc + 67);
    send_frame(9'h041, 7, 6, 1, 1, 2, 1, -1, 0);
    tick(12);
    push(8'h41, 1, 0, 0, -1);
    send_frame(9'h041, 7, 6, 1, 0, 2, 1, -1, 0);
    tick(12);
    push(8'h41, 0, 1, 0, -1);
    send_frame(9'h041, 7, 6, 1, 1, 2, 0, -1, 0);
    tick(12);

    // 3-cycle start glitch.
    cfg(8, 8, 0, 0, 0);
    RX_IN = 1'b0;
    tick(3);
    RX_IN = 1'b1;
    tick(16);
    chk("start_glitch_state", 32'(dut.state), 32'(IDLE));
    chk("start_glitch_valid", 32'(data_valid), 32'd0);

    // Break: 20 bit times low.
    push(8'h00, 0, 1, 1, -1);
    RX_IN = 1'b0;
    tick(15 * 8);
    chk("break_wait_high", 32'(dut.state), 32'(WAIT_HIGH));
    tick(5 * 8);
    RX_IN = 1'b1;
    tick(24);
    chk("break_idle", 32'(dut.state), 32'(IDLE));

    // Overrun: consumer stalled, second frame dropped.
    data_ready = 1'b0;
    ovr0 = ovr_cnt;
    push(8'h11, 0, 0, 0, -1);
    send_frame(9'h011, 8, 8, 0, 0, 1, 1, -1, 0);
    send_frame(9'h022, 8, 8, 0, 0, 1, 1, -1, 0);
    tick(8);
    chk("overrun_hold_data", 32'(P_DATA), 32'h11);
    chk("overrun_hold_valid", 32'(data_valid), 32'd1);
    chk("overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);

    // Ready asserted exactly on the load edge: held frame leaves, new one enters.
    ovr0 = ovr_cnt;
    push(8'h22, 0, 0, 0, -1);
    fork
      send_frame(9'h022, 8, 8, 0, 0, 1, 1, -1, 0);
      begin
        tick(79);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
      end
    join
    tick(8);
    chk("replace_data", 32'(P_DATA), 32'h22);
    chk("replace_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);
    data_ready = 1'b1;
    tick(2);
    chk("drain_valid", 32'(data_valid), 32'd0);

    // Reset in the middle of the data bits.
    RX_IN = 1'b0;
    tick(8);
    RX_IN = 1'b1;
    tick(8);
    RX_IN = 1'b0;
    tick(4);
    chk("midframe_state", 32'(dut.state), 32'(DATA));
    RST = 1'b0;
    tick(2);
    chk("midframe_reset_outputs", 32'({P_DATA, data_valid, par_err, frm_err, brk_det, overrun}), 32'd0);
    chk("midframe_reset_state", 32'(dut.state), 32'(IDLE));
    RX_IN = 1'b1;
    tick(2);
    RST = 1'b1;
    tick(16);
    push(8'h5A, 0, 0, 0, -1);
    send_frame(9'h05A, 8, 8, 0, 0, 1, 1, -1, 0);

    for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick(1);
    tick(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("total_overruns", 32'(ovr_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
